// File: rtl/tx_beamformer_pkg.sv
// tx_beamformer_pkg: shared FSM state type and parameter derivations for the TX beamformer
package tx_beamformer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FIRE = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int delay_width(input int max_delay);
        return $clog2(max_delay);
    endfunction

    function automatic int burst_len(input int half_period, input int num_half_cycles);
        return half_period * num_half_cycles;
    endfunction

    // One spare bit so tick can reach max_delay + BURST_LEN without wrapping.
    function automatic int tick_width(input int dw, input int bl);
        return dw + $clog2(bl) + 1;
    endfunction

endpackage

// File: rtl/tx_pulse_gen.sv
// tx_pulse_gen: per-channel combinational bipolar burst decode
//   tick    - cycles elapsed since FIRE began
//   fire_en - high only while the top is in FIRE
//   delay   - this channel's focal delay in clk cycles
//   pos/neg - positive/negative drive request (never both high)
module tx_pulse_gen
    import tx_beamformer_pkg::*;
#(
    parameter int DELAY_WIDTH = 8,
    parameter int TICK_WIDTH  = 12,
    parameter int HALF_PERIOD = 2,
    parameter int BURST_LEN   = 8
) (
    input  logic [TICK_WIDTH-1:0]  tick,
    input  logic                   fire_en,
    input  logic [DELAY_WIDTH-1:0] delay,
    output logic                   pos,
    output logic                   neg
);

    logic [TICK_WIDTH-1:0] rel;
    logic                  active;
    logic                  odd;

    always_comb begin
        rel    = tick - TICK_WIDTH'(delay);
        active = fire_en && (tick >= TICK_WIDTH'(delay)) && (rel < TICK_WIDTH'(BURST_LEN));
        odd    = ((32'(rel) / HALF_PERIOD) % 2) != 0;
        pos    = active && !odd;
        neg    = active && odd;
    end

endmodule

// File: rtl/tx_beamformer.sv
// tx_beamformer: latches a focal delay vector and fires a delayed bipolar burst per channel
//   clk, reset  - sole clock, synchronous active-high reset
//   start       - begins a firing, sampled only in IDLE
//   delay_flat  - channel i delay at [i*DELAY_WIDTH +: DELAY_WIDTH]
//   tx_pos/neg  - registered per-channel drive
//   busy        - state != IDLE
//   done        - one-cycle pulse in the DONE state
//   debug_state - current FSM state
module tx_beamformer
    import tx_beamformer_pkg::*;
#(
    parameter int  NUM_CHANNELS    = 16,
    parameter int  MAX_DELAY       = 256,
    parameter int  HALF_PERIOD     = 2,
    parameter int  NUM_HALF_CYCLES = 4,
    localparam int DELAY_WIDTH     = delay_width(MAX_DELAY)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [NUM_CHANNELS*DELAY_WIDTH-1:0] delay_flat,
    output logic [NUM_CHANNELS-1:0]             tx_pos,
    output logic [NUM_CHANNELS-1:0]             tx_neg,
    output logic                                busy,
    output logic                                done,
    output logic [1:0]                          debug_state
);

    localparam int BURST_LEN  = burst_len(HALF_PERIOD, NUM_HALF_CYCLES);
    localparam int TICK_WIDTH = tick_width(DELAY_WIDTH, BURST_LEN);
    localparam int IDX_WIDTH  = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;

    state_t                 state;
    logic [DELAY_WIDTH-1:0] delay_reg [NUM_CHANNELS];
    logic [DELAY_WIDTH-1:0] max_delay;
    logic [IDX_WIDTH-1:0]   scan_idx;
    logic [TICK_WIDTH-1:0]  tick;
    logic [NUM_CHANNELS-1:0] pos_next;
    logic [NUM_CHANNELS-1:0] neg_next;
    logic                   scan_last;
    logic                   tick_last;
    logic                   fire_en;

    assign scan_last   = scan_idx == IDX_WIDTH'(NUM_CHANNELS - 1);
    assign tick_last   = tick == TICK_WIDTH'(max_delay) + TICK_WIDTH'(BURST_LEN - 1);
    assign fire_en     = state == FIRE;
    assign debug_state = state;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        tx_pulse_gen #(
            .DELAY_WIDTH(DELAY_WIDTH),
            .TICK_WIDTH (TICK_WIDTH),
            .HALF_PERIOD(HALF_PERIOD),
            .BURST_LEN  (BURST_LEN)
        ) u_pulse (
            .tick   (tick),
            .fire_en(fire_en),
            .delay  (delay_reg[i]),
            .pos    (pos_next[i]),
            .neg    (neg_next[i])
        );
    end

    // Decode is gated by fire_en, so outside FIRE the registers load zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tick      <= '0;
            scan_idx  <= '0;
            max_delay <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) delay_reg[i] <= '0;
            tx_pos    <= '0;
            tx_neg    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            tx_pos <= pos_next;
            tx_neg <= neg_next;
            done   <= 1'b0;
            unique case (state)
                IDLE: if (start) begin
                    for (int i = 0; i < NUM_CHANNELS; i++)
                        delay_reg[i] <= delay_flat[i*DELAY_WIDTH +: DELAY_WIDTH];
                    max_delay <= '0;
                    scan_idx  <= '0;
                    busy      <= 1'b1;
                    state     <= SCAN;
                end
                SCAN: begin
                    max_delay <= delay_reg[scan_idx] > max_delay ? delay_reg[scan_idx] : max_delay;
                    scan_idx  <= scan_idx + 1'b1;
                    if (scan_last) begin
                        tick  <= '0;
                        state <= FIRE;
                    end
                end
                FIRE: begin
                    tick <= tick + 1'b1;
                    if (tick_last) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_beamformer.sv
// tb_tx_beamformer: directed self-checking bench for tx_beamformer
module tb_tx_beamformer;

    localparam int N   = 16;
    localparam int DW  = 8;
    localparam int HP  = 2;
    localparam int NHC = 4;
    localparam int BL  = HP * NHC;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [N*DW-1:0]   delay_flat = '0;
    logic [N-1:0]      tx_pos;
    logic [N-1:0]      tx_neg;
    logic              busy;
    logic              done;
    logic [1:0]        debug_state;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    tx_beamformer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .delay_flat (delay_flat),
        .tx_pos     (tx_pos),
        .tx_neg     (tx_neg),
        .busy       (busy),
        .done       (done),
        .debug_state(debug_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs r cycles after the start sample, straight from the timing description.
    function automatic void model(input logic [N*DW-1:0] dl, input int r,
                                  output logic [N-1:0] ep, output logic [N-1:0] en,
                                  output logic ed, output logic eb, output logic [1:0] es);
        int maxd = 0;
        for (int i = 0; i < N; i++) if (int'(dl[i*DW +: DW]) > maxd) maxd = int'(dl[i*DW +: DW]);
        es = r == 0 ? 2'd0 : r <= N ? 2'd1 : r <= N + maxd + BL ? 2'd2 : r == N + 1 + maxd + BL ? 2'd3 : 2'd0;
        eb = r >= 1 && r <= N + 1 + maxd + BL;
        ed = r == N + 1 + maxd + BL;
        for (int i = 0; i < N; i++) begin
            int k = r - (N + 2) - int'(dl[i*DW +: DW]);
            ep[i] = k >= 0 && k < BL && ((k / HP) % 2) == 0;
            en[i] = k >= 0 && k < BL && ((k / HP) % 2) == 1;
        end
    endfunction

    // mode 0: plain, 1: extra starts + delay change, 2: start held, 3: reset at cycle 30
    task automatic run(input string tag, input logic [N*DW-1:0] dl, input int ncyc, input int mode);
        logic [N-1:0] ep, en;
        logic ed, eb;
        logic [1:0] es;
        for (int c = 0; c < ncyc; c++) begin
            start      = c == 0 || mode == 2 || (mode == 1 && (c == 5 || c == 40));
            delay_flat = (mode == 1 && c >= 3) ? ~dl : dl;
            reset      = mode == 3 && c == 30;
            model(dl, mode == 2 ? c % (N + 2 + BL + 8 * 0 + (0)) : c, ep, en, ed, eb, es);
            if (mode == 2) model(dl, c % (N + 2 + BL), ep, en, ed, eb, es);
            check($sformatf("%s tx_pos c%0d", tag, c), 32'(tx_pos), 32'(ep));
            check($sformatf("%s tx_neg c%0d", tag, c), 32'(tx_neg), 32'(en));
            check($sformatf("%s done c%0d", tag, c), 32'(done), 32'(ed));
            check($sformatf("%s busy c%0d", tag, c), 32'(busy), 32'(eb));
            check($sformatf("%s state c%0d", tag, c), 32'(debug_state), 32'(es));
            check($sformatf("%s overlap c%0d", tag, c), 32'(tx_pos & tx_neg), 32'd0);
            step();
        end
        start = 1'b0;
        reset = 1'b0;
    endtask

    logic [N*DW-1:0] zeros, ramp, ch7;

    initial begin
        zeros = '0;
        ramp  = '0;
        ch7   = '0;
        for (int i = 0; i < N; i++) ramp[i*DW +: DW] = DW'(4 * i);
        ch7[7*DW +: DW] = 8'd255;
        repeat (3) step();
        check("reset tx_pos", 32'(tx_pos), 32'd0);
        check("reset tx_neg", 32'(tx_neg), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset state", 32'(debug_state), 32'd0);
        reset = 1'b0;
        repeat (2) step();
        run("zero", zeros, 27 + 2, 0);
        repeat (2) step();
        run("ramp", ramp, 27 + 60 + 2, 0);
        repeat (2) step();
        run("ch7", ch7, 27 + 255 + 2, 0);
        repeat (2) step();
        run("restart", ramp, 27 + 60 + 2, 1);
        repeat (2) step();
        run("midreset", ramp, 31, 3);
        check("post-reset tx_pos", 32'(tx_pos), 32'd0);
        check("post-reset tx_neg", 32'(tx_neg), 32'd0);
        check("post-reset busy", 32'(busy), 32'd0);
        check("post-reset done", 32'(done), 32'd0);
        check("post-reset state", 32'(debug_state), 32'd0);
        step();
        run("after-reset", ramp, 27 + 60 + 2, 0);
        repeat (2) step();
        run("b2b", zeros, 52, 2);
        check("b2b idle after", 32'(debug_state), 32'd0);
        step();
        check("b2b no third firing", 32'(debug_state), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
